// File: rtl/arm_pkg.sv
// Shared ARM decode definitions: opcodes, EXE commands, condition codes,
// the control bundle and the decode/condition helper functions.
package arm_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       s;
    } ctrl_t;

    // status is {N, Z, C, V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            CC_EQ:   return z;
            CC_NE:   return ~z;
            CC_CS:   return c;
            CC_CC:   return ~c;
            CC_MI:   return n;
            CC_PL:   return ~n;
            CC_VS:   return v;
            CC_VC:   return ~v;
            CC_HI:   return c & ~z;
            CC_LS:   return ~c | z;
            CC_GE:   return n == v;
            CC_LT:   return n != v;
            CC_GT:   return ~z & (n == v);
            CC_LE:   return z | (n != v);
            CC_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        unique case (instr[27:26])
            MODE_DP: begin
                c.s     = instr[20];
                c.wb_en = 1'b1;
                case (instr[24:21])
                    OP_MOV:  c.exe_cmd = EXE_MOV;
                    OP_MVN:  c.exe_cmd = EXE_MVN;
                    OP_ADD:  c.exe_cmd = EXE_ADD;
                    OP_ADC:  c.exe_cmd = EXE_ADC;
                    OP_SUB:  c.exe_cmd = EXE_SUB;
                    OP_SBC:  c.exe_cmd = EXE_SBC;
                    OP_AND:  c.exe_cmd = EXE_AND;
                    OP_ORR:  c.exe_cmd = EXE_ORR;
                    OP_EOR:  c.exe_cmd = EXE_EOR;
                    OP_CMP:  begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b0; end
                    OP_TST:  begin c.exe_cmd = EXE_AND; c.wb_en = 1'b0; end
                    default: c.wb_en = 1'b0;
                endcase
            end
            MODE_MEM: begin
                c.exe_cmd   = EXE_ADD;
                c.mem_read  = instr[20];
                c.wb_en     = instr[20];
                c.mem_write = ~instr[20];
            end
            MODE_BR: c.b = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Write-pending scoreboard: a shift register of {valid, dst} per
// post-ID stage plus the address-hit compare used for RAW detection.
module id_scoreboard
    import arm_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_dst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              hit_a,
    output logic              hit_b
);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] dst [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) dst[i] <= '0;
        end else if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid[i] <= valid[i-1];
                dst[i]   <= dst[i-1];
            end
            valid[0] <= load_valid;
            dst[0]   <= load_dst;
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a = hit_a | (valid[i] & (dst[i] == addr_a));
            hit_b = hit_b | (valid[i] & (dst[i] == addr_b));
        end
    end

endmodule

// File: rtl/id_stage_sb.sv
// ARM decode stage with register file, condition check, ID/EX register and
// internal RAW scoreboard. Define ID_WB_BYPASS_EN for same-cycle WB bypass.
module id_stage_sb
    import arm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int SB_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  if_valid,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           instr_in,
    input  logic [3:0]            status_reg,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  if_ready,
    output logic                  id_valid,
    output logic [31:0]           pc_out,
    output logic [DATA_W-1:0]     val_rn,
    output logic [DATA_W-1:0]     val_rm,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dst,
    output logic [3:0]            exe_cmd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic                  imm,
    output logic [11:0]           shifter_operand,
    output logic [23:0]           signed_imm
);

`ifdef ID_WB_BYPASS_EN
    localparam int SB_D = SB_DEPTH;
`else
    localparam int SB_D = SB_DEPTH + 1;
`endif

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [DATA_W-1:0]     rn;
        logic [DATA_W-1:0]     rm;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [REG_ADDR_W-1:0] dst;
        ctrl_t                 ctrl;
        logic                  imm;
        logic [11:0]           shop;
        logic [23:0]           simm;
    } id_ex_t;

    logic [DATA_W-1:0] rf [2**REG_ADDR_W];

    logic [REG_ADDR_W-1:0] a1, a2, ad;
    logic                  store, has_src1, has_src2, pass;
    logic                  hit1, hit2, stall, bubble;
    logic [DATA_W-1:0]     rd1, rd2;
    ctrl_t                 ctrl;
    id_ex_t                nxt, q;

    assign store = (instr_in[27:26] == MODE_MEM) & ~instr_in[20];
    assign a1    = REG_ADDR_W'(instr_in[19:16]);
    assign a2    = store ? REG_ADDR_W'(instr_in[15:12])
                         : REG_ADDR_W'(instr_in[3:0]);
    assign ad    = REG_ADDR_W'(instr_in[15:12]);

    assign has_src1 = ~((instr_in[27:26] == MODE_BR) |
                        ((instr_in[27:26] == MODE_DP) &
                         ((instr_in[24:21] == OP_MOV) |
                          (instr_in[24:21] == OP_MVN))));
    assign has_src2 = ~instr_in[25] | store;

    assign pass = cond_pass(instr_in[31:28], status_reg);
    assign ctrl = pass ? decode_ctrl(instr_in) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign rd1 = (wb_en && wb_addr == a1) ? wb_data : rf[a1];
    assign rd2 = (wb_en && wb_addr == a2) ? wb_data : rf[a2];
`else
    assign rd1 = rf[a1];
    assign rd2 = rf[a2];
`endif

    id_scoreboard #(.DEPTH(SB_D), .ADDR_W(REG_ADDR_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .en         (~freeze),
        .load_valid (~bubble & if_valid & ctrl.wb_en),
        .load_dst   (ad),
        .addr_a     (a1),
        .addr_b     (a2),
        .hit_a      (hit1),
        .hit_b      (hit2)
    );

    assign stall    = if_valid & ((has_src1 & hit1) | (has_src2 & hit2));
    assign bubble   = flush | stall;
    assign if_ready = ~freeze & (flush | ~stall);

    always_comb begin
        nxt       = '0;
        nxt.valid = if_valid;
        nxt.pc    = pc_in;
        nxt.rn    = rd1;
        nxt.rm    = rd2;
        nxt.src1  = a1;
        nxt.src2  = a2;
        nxt.dst   = ad;
        nxt.ctrl  = ctrl;
        nxt.imm   = instr_in[25];
        nxt.shop  = instr_in[11:0];
        nxt.simm  = instr_in[23:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          q <= '0;
        else if (!freeze) q <= bubble ? '0 : nxt;
    end

    assign id_valid        = q.valid;
    assign pc_out          = q.pc;
    assign val_rn          = q.rn;
    assign val_rm          = q.rm;
    assign src1            = q.src1;
    assign src2            = q.src2;
    assign dst             = q.dst;
    assign exe_cmd         = q.ctrl.exe_cmd;
    assign mem_read        = q.ctrl.mem_read;
    assign mem_write       = q.ctrl.mem_write;
    assign wb_en_out       = q.ctrl.wb_en;
    assign b_out           = q.ctrl.b;
    assign s_out           = q.ctrl.s;
    assign imm             = q.imm;
    assign shifter_operand = q.shop;
    assign signed_imm      = q.simm;

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb; bubble counts follow ID_WB_BYPASS_EN.
module tb_id_stage_sb;

    logic        clk = 0;
    logic        rst, freeze, flush, if_valid, wb_en;
    logic [31:0] pc_in, instr_in, wb_data;
    logic [3:0]  status_reg, wb_addr;
    logic        if_ready, id_valid, mem_read, mem_write, wb_en_out;
    logic        b_out, s_out, imm;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [3:0]  src1, src2, dst, exe_cmd;
    logic [11:0] shifter_operand;
    logic [23:0] signed_imm;

    int tests = 0;
    int fails = 0;
    int bub;
    bit got;

`ifdef ID_WB_BYPASS_EN
    localparam int RAW_BUB = 2;
    localparam int STR_BUB = 0;
`else
    localparam int RAW_BUB = 3;
    localparam int STR_BUB = 1;
`endif

    always #5 clk = ~clk;

    id_stage_sb dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .if_valid(if_valid), .pc_in(pc_in), .instr_in(instr_in),
        .status_reg(status_reg), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .if_ready(if_ready), .id_valid(id_valid),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm),
        .src1(src1), .src2(src2), .dst(dst), .exe_cmd(exe_cmd),
        .mem_read(mem_read), .mem_write(mem_write), .wb_en_out(wb_en_out),
        .b_out(b_out), .s_out(s_out), .imm(imm),
        .shifter_operand(shifter_operand), .signed_imm(signed_imm)
    );

    function automatic logic [31:0] dp(input logic [3:0] c, input logic i,
                                       input logic [3:0] op, input logic [3:0] rn,
                                       input logic [3:0] rd, input logic [11:0] o2);
        return {c, 2'b00, i, op, 1'b0, rn, rd, o2};
    endfunction

    function automatic logic [31:0] ldst(input logic l, input logic [3:0] rn,
                                         input logic [3:0] rd);
        return {4'hE, 2'b01, 1'b0, 4'b0100, l, rn, rd, 12'h000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic v, input logic [31:0] pc);
        instr_in = ins;
        if_valid = v;
        pc_in    = pc;
    endtask

    task automatic idle(input int n);
        put(32'h0, 1'b0, 32'h0);
        repeat (n) tick();
    endtask

    // Holds the current instruction until it issues; wb of R1 at cycle wbk
    task automatic wait_issue(input int wbk, output int nb, output bit ok);
        nb = 0;
        ok = 0;
        for (int k = 0; k < 8 && !ok; k++) begin
            wb_en   = (k == wbk);
            wb_addr = 4'd1;
            wb_data = 32'h1234;
            #1;
            if (if_ready) ok = 1;
            else nb++;
            tick();
            if (!ok) chk("stall_bubble_valid", id_valid, 0);
        end
        wb_en = 0;
        chk("issue_within_bound", ok, 1);
    endtask

    initial begin
        rst = 1; freeze = 0; flush = 0; if_valid = 0; pc_in = 0; instr_in = 0;
        status_reg = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        tick();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_dst", dst, 0);
        chk("rst_wb_en_out", wb_en_out, 0);
        chk("rst_if_ready", if_ready, 1);
        rst = 0;

        wb_en = 1;
        wb_addr = 2; wb_data = 32'h22; tick();
        wb_addr = 3; wb_data = 32'h33; tick();
        wb_addr = 5; wb_data = 32'h55; tick();
        wb_en = 0;

        put(dp(4'hE, 1, 4'b1101, 4'd0, 4'd1, 12'h005), 1, 32'h100);
        #1 chk("mov1_ready", if_ready, 1);
        tick();
        chk("mov1_valid", id_valid, 1);
        chk("mov1_dst", dst, 1);
        chk("mov1_exe", exe_cmd, 4'b0001);
        chk("mov1_imm", imm, 1);
        chk("mov1_shop", shifter_operand, 12'h005);
        chk("mov1_wb", wb_en_out, 1);
        chk("mov1_pc", pc_out, 32'h100);
        put(dp(4'hE, 1, 4'b1101, 4'd0, 4'd2, 12'h007), 1, 32'h104);
        #1 chk("mov2_ready", if_ready, 1);
        tick();
        chk("mov2_valid", id_valid, 1);
        chk("mov2_dst", dst, 2);
        idle(4);

        put(dp(4'hE, 0, 4'b0100, 4'd2, 4'd1, 12'h003), 1, 32'h200);
        tick();
        chk("add1_valid", id_valid, 1);
        chk("add1_rn", val_rn, 32'h22);
        chk("add1_rm", val_rm, 32'h33);
        chk("add1_exe", exe_cmd, 4'b0010);
        chk("add1_pc", pc_out, 32'h200);
        put(dp(4'hE, 0, 4'b0100, 4'd1, 4'd4, 12'h005), 1, 32'h204);
        wait_issue(2, bub, got);
        chk("raw_bubbles", bub, RAW_BUB);
        chk("raw_valid", id_valid, 1);
        chk("raw_src1", src1, 1);
        chk("raw_rn", val_rn, 32'h1234);
        chk("raw_rm", val_rm, 32'h55);
        idle(4);

        put(dp(4'hE, 0, 4'b0100, 4'd2, 4'd1, 12'h003), 1, 32'h300);
        tick();
        put(ldst(0, 4'd2, 4'd1), 1, 32'h304);
        freeze = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("frz_ready", if_ready, 0);
            tick();
            chk("frz_valid_held", id_valid, 1);
            chk("frz_dst_held", dst, 1);
        end
        freeze = 0;
        #1 chk("str_src2_stall", if_ready, 0);
        tick();
        chk("str_bubble", id_valid, 0);
        flush = 1;
        #1 chk("flush_ready", if_ready, 1);
        tick();
        chk("flush_valid", id_valid, 0);
        chk("flush_mem_write", mem_write, 0);
        flush = 0;
        wait_issue(-1, bub, got);
        chk("str_bubbles", bub, STR_BUB);
        chk("str_valid", id_valid, 1);
        chk("str_mem_write", mem_write, 1);
        chk("str_src2", src2, 1);
        chk("str_wb", wb_en_out, 0);
        idle(4);

        status_reg = 4'b0000;
        put(dp(4'h0, 0, 4'b0100, 4'd2, 4'd1, 12'h003), 1, 32'h400);
        tick();
        chk("condfail_valid", id_valid, 1);
        chk("condfail_wb", wb_en_out, 0);
        chk("condfail_exe", exe_cmd, 0);
        put(dp(4'hE, 0, 4'b0100, 4'd1, 4'd4, 12'h005), 1, 32'h404);
        #1 chk("condfail_no_stall", if_ready, 1);
        tick();
        chk("condfail_next_valid", id_valid, 1);
        status_reg = 4'b0100;
        put(dp(4'h0, 0, 4'b0100, 4'd2, 4'd6, 12'h003), 1, 32'h408);
        tick();
        chk("condpass_wb", wb_en_out, 1);
        chk("condpass_dst", dst, 6);

        #2 rst = 1;
        #1;
        chk("midrst_valid", id_valid, 0);
        chk("midrst_dst", dst, 0);
        chk("midrst_pc", pc_out, 0);
        tick();
        rst = 0;
        put(dp(4'hE, 0, 4'b0100, 4'd2, 4'd7, 12'h006), 1, 32'h500);
        #1 chk("midrst_no_stall", if_ready, 1);
        tick();
        chk("midrst_issue", id_valid, 1);
        chk("midrst_rf_cleared", val_rn, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
